// File: rtl/traffic_pkg.sv
// Shared encodings for the intersection controller and its safety monitor:
// light codes, direction indices, violation codes and the tracker state.
package traffic_pkg;

    localparam logic [1:0] LT_RED = 2'b00;
    localparam logic [1:0] LT_YEL = 2'b01;
    localparam logic [1:0] LT_GRN = 2'b10;
    localparam logic [1:0] LT_BAD = 2'b11;

    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_E = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;
    localparam int         NUM_DIR = 4;

    localparam logic [2:0] ERR_NONE        = 3'd0;
    localparam logic [2:0] ERR_ILLEGAL     = 3'd1;
    localparam logic [2:0] ERR_CONFLICT    = 3'd2;
    localparam logic [2:0] ERR_BAD_TRANS   = 3'd3;
    localparam logic [2:0] ERR_ORDER       = 3'd4;
    localparam logic [2:0] ERR_GREEN_SHORT = 3'd5;
    localparam logic [2:0] ERR_GREEN_LONG  = 3'd6;
    localparam logic [2:0] ERR_YELLOW_LEN  = 3'd7;

    typedef enum logic [1:0] {
        TRK_ALLRED = 2'd0,
        TRK_GREEN  = 2'd1,
        TRK_YELLOW = 2'd2
    } trk_state_e;

    // Bit i of v set means violation code i was raised; the lowest wins.
    function automatic logic [2:0] lowest_code(input logic [7:0] v);
        logic [2:0] c;
        c = ERR_NONE;
        for (int i = 7; i >= 1; i--) begin
            if (v[i]) c = 3'(i);
        end
        return c;
    endfunction

endpackage

// File: rtl/light_trans_chk.sv
// Per-direction colour history: remembers last sampled colour and decodes
// the transition seen this cycle. Moves into or out of 11 are never "bad_trans".
module light_trans_chk
    import traffic_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] light,
    output logic       is_bad,
    output logic       is_r2g,
    output logic       is_g2y,
    output logic       is_y2r,
    output logic       is_bad_trans
);

    logic [1:0] prev_q, prev_d;

    always_comb prev_d = light;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) prev_q <= LT_RED;
        else      prev_q <= prev_d;
    end

    always_comb begin
        is_bad       = (light == LT_BAD);
        is_r2g       = (prev_q == LT_RED) && (light == LT_GRN);
        is_g2y       = (prev_q == LT_GRN) && (light == LT_YEL);
        is_y2r       = (prev_q == LT_YEL) && (light == LT_RED);
        is_bad_trans = ((prev_q == LT_RED) && (light == LT_YEL)) ||
                       ((prev_q == LT_GRN) && (light == LT_RED)) ||
                       ((prev_q == LT_YEL) && (light == LT_GRN));
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive safety watchdog for the 4-way light controller: tracks the active
// phase, checks codes, exclusion, sequencing, rotation order and phase timing.
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int YELLOW_CYC = 2,
    parameter int MIN_GREEN  = 3,
    parameter int MAX_GREEN  = 16,
    parameter int TIMER_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic [1:0] North_light,
    input  logic [1:0] East_light,
    input  logic [1:0] South_light,
    input  logic [1:0] West_light,
    output logic       err_pulse,
    output logic       err_flag,
    output logic [2:0] err_code,
    output logic [7:0] err_cnt,
    output logic [1:0] active_dir,
    output logic       active_vld,
    output logic [7:0] rot_cnt
);

    localparam logic [TIMER_W-1:0] TMR_MAX    = {TIMER_W{1'b1}};
    localparam logic [TIMER_W-1:0] GRN_MIN_T  = TIMER_W'(MIN_GREEN - 1);
    localparam logic [TIMER_W-1:0] GRN_LONG_T = TIMER_W'(MAX_GREEN - 1);
    localparam logic [TIMER_W-1:0] YEL_T      = TIMER_W'(YELLOW_CYC - 1);

    logic [NUM_DIR-1:0][1:0] lights;
    logic [NUM_DIR-1:0]      bad, r2g, g2y, y2r, btr, nonred;

    assign lights = {West_light, South_light, East_light, North_light};

    for (genvar g = 0; g < NUM_DIR; g++) begin : g_dir
        light_trans_chk u_chk (
            .clk          (clk),
            .rst          (rst),
            .light        (lights[g]),
            .is_bad       (bad[g]),
            .is_r2g       (r2g[g]),
            .is_g2y       (g2y[g]),
            .is_y2r       (y2r[g]),
            .is_bad_trans (btr[g])
        );
        assign nonred[g] = (lights[g] != LT_RED);
    end

    // Lowest-index non-red direction is the one the tracker latches onto.
    logic [1:0] sel;
    logic       sel_vld;
    always_comb begin
        sel     = DIR_N;
        sel_vld = 1'b0;
        for (int i = NUM_DIR - 1; i >= 0; i--) begin
            if (nonred[i]) begin
                sel     = 2'(i);
                sel_vld = 1'b1;
            end
        end
    end

    trk_state_e         state_q, state_d;
    logic [1:0]         dir_q, dir_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               green_entry;
    logic [1:0]         cur;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= TRK_ALLRED;
            dir_q   <= DIR_N;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            timer_q <= timer_d;
        end
    end

    // Beyond the legal arcs, a tracked light that drops straight to red (or
    // jumps back to green) resyncs the tracker so timing checks stay sane.
    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        green_entry = 1'b0;
        cur         = lights[dir_q];
        case (state_q)
            TRK_ALLRED: if (sel_vld && r2g[sel]) begin
                state_d     = TRK_GREEN;
                dir_d       = sel;
                green_entry = 1'b1;
            end
            TRK_GREEN: begin
                if (cur == LT_YEL)      state_d = TRK_YELLOW;
                else if (cur == LT_RED) state_d = TRK_ALLRED;
            end
            TRK_YELLOW: begin
                if (cur == LT_RED)      state_d = TRK_ALLRED;
                else if (cur == LT_GRN) state_d = TRK_GREEN;
            end
            default: state_d = TRK_ALLRED;
        endcase
        if (state_d != state_q)     timer_d = '0;
        else if (timer_q == TMR_MAX) timer_d = timer_q;
        else                        timer_d = timer_q + 1'b1;
    end

    always_comb begin
        active_vld = (state_q != TRK_ALLRED);
        active_dir = active_vld ? dir_q : DIR_N;
    end

    logic       order_armed_q, order_armed_d;
    logic [1:0] exp_dir_q, exp_dir_d;
    logic       ord_ok_q, ord_ok_d;
    logic [7:0] err_v;
    logic       any_err;

    // Timer holds (samples in phase - 1), so lengths compare against N-1.
    always_comb begin
        err_v                  = '0;
        err_v[ERR_ILLEGAL]     = |bad;
        err_v[ERR_CONFLICT]    = (nonred & (nonred - 4'd1)) != '0;
        err_v[ERR_BAD_TRANS]   = |btr;
        err_v[ERR_ORDER]       = green_entry && order_armed_q && (dir_d != exp_dir_q);
        err_v[ERR_GREEN_SHORT] = (state_q == TRK_GREEN) && g2y[dir_q] && (timer_q < GRN_MIN_T);
        err_v[ERR_GREEN_LONG]  = (state_q == TRK_GREEN) && (cur == LT_GRN) && (timer_q == GRN_LONG_T);
        err_v[ERR_YELLOW_LEN]  = (state_q == TRK_YELLOW) && y2r[dir_q] && (timer_q != YEL_T);
        any_err                = |err_v;
    end

    logic       err_pulse_q, err_pulse_d;
    logic       err_flag_q, err_flag_d;
    logic [2:0] err_code_q, err_code_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic [7:0] rot_cnt_q, rot_cnt_d;

    always_comb begin
        err_pulse_d   = any_err;
        err_flag_d    = err_flag_q | any_err;
        err_code_d    = (any_err && !err_flag_q) ? lowest_code(err_v) : err_code_q;
        err_cnt_d     = (any_err && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
        order_armed_d = order_armed_q;
        exp_dir_d     = exp_dir_q;
        ord_ok_d      = ord_ok_q;
        if (green_entry) begin
            order_armed_d = 1'b1;
            exp_dir_d     = dir_d + 2'd1;
            if (dir_d == DIR_N)          ord_ok_d = !err_v[ERR_ORDER];
            else if (err_v[ERR_ORDER])   ord_ok_d = 1'b0;
        end
        rot_cnt_d = (y2r[DIR_W] && order_armed_q && ord_ok_q) ? rot_cnt_q + 8'd1 : rot_cnt_q;
        if (clr) begin
            err_flag_d    = 1'b0;
            err_code_d    = ERR_NONE;
            err_cnt_d     = '0;
            order_armed_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_pulse_q   <= 1'b0;
            err_flag_q    <= 1'b0;
            err_code_q    <= ERR_NONE;
            err_cnt_q     <= '0;
            rot_cnt_q     <= '0;
            order_armed_q <= 1'b0;
            exp_dir_q     <= DIR_N;
            ord_ok_q      <= 1'b0;
        end else begin
            err_pulse_q   <= err_pulse_d;
            err_flag_q    <= err_flag_d;
            err_code_q    <= err_code_d;
            err_cnt_q     <= err_cnt_d;
            rot_cnt_q     <= rot_cnt_d;
            order_armed_q <= order_armed_d;
            exp_dir_q     <= exp_dir_d;
            ord_ok_q      <= ord_ok_d;
        end
    end

    assign err_pulse = err_pulse_q;
    assign err_flag  = err_flag_q;
    assign err_code  = err_code_q;
    assign err_cnt   = err_cnt_q;
    assign rot_cnt   = rot_cnt_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench: directed light vectors push hand-computed expectations,
// a monitor pops and compares them after each rising edge.
module tb_traffic_light_monitor;
    import traffic_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr = 1'b0;
    logic [1:0] nl = LT_RED, el = LT_RED, sl = LT_RED, wl = LT_RED;
    logic       err_pulse, err_flag, active_vld;
    logic [2:0] err_code;
    logic [7:0] err_cnt, rot_cnt;
    logic [1:0] active_dir;

    traffic_light_monitor dut (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .North_light (nl),
        .East_light  (el),
        .South_light (sl),
        .West_light  (wl),
        .err_pulse   (err_pulse),
        .err_flag    (err_flag),
        .err_code    (err_code),
        .err_cnt     (err_cnt),
        .active_dir  (active_dir),
        .active_vld  (active_vld),
        .rot_cnt     (rot_cnt)
    );

    always #5 clk = ~clk;

    // A field value of -1 means "don't care" for that step.
    typedef struct {
        int tst, idx;
        int pulse, flag, code, cnt, vld, dir, rot;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0, n_bad = 0;
    int tnum = 0, sidx = 0;

    task automatic cmp(input int t, input int i, input string nm, input int act, input int exp);
        if (exp < 0) return;
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL T%0d step %0d %s: got %0d, want %0d", t, i, nm, act, exp);
        end
    endtask

    always @(posedge clk) begin : mon
        exp_t e;
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            cmp(e.tst, e.idx, "err_pulse",  int'(err_pulse),  e.pulse);
            cmp(e.tst, e.idx, "err_flag",   int'(err_flag),   e.flag);
            cmp(e.tst, e.idx, "err_code",   int'(err_code),   e.code);
            cmp(e.tst, e.idx, "err_cnt",    int'(err_cnt),    e.cnt);
            cmp(e.tst, e.idx, "active_vld", int'(active_vld), e.vld);
            cmp(e.tst, e.idx, "active_dir", int'(active_dir), e.dir);
            cmp(e.tst, e.idx, "rot_cnt",    int'(rot_cnt),    e.rot);
        end
    end

    task automatic apply(input logic [1:0] n, e, s, w, input logic c,
                         input int p, f, cd, cn, v, d, r);
        exp_t x;
        nl = n; el = e; sl = s; wl = w; clr = c;
        x.tst = tnum; x.idx = sidx;
        x.pulse = p; x.flag = f; x.code = cd; x.cnt = cn;
        x.vld = v; x.dir = d; x.rot = r;
        sidx++;
        q.push_back(x);
    endtask

    task automatic step(input logic [1:0] n, e, s, w, input logic c,
                        input int p, f, cd, cn, v, d, r);
        @(negedge clk);
        apply(n, e, s, w, c, p, f, cd, cn, v, d, r);
    endtask

    // Only direction d lit with colour c, others red.
    task automatic lt(input int d, input logic [1:0] c, input logic cl,
                      input int p, f, cd, cn, v, dr, r);
        logic [1:0] l [4];
        for (int i = 0; i < 4; i++) l[i] = (i == d) ? c : LT_RED;
        step(l[0], l[1], l[2], l[3], cl, p, f, cd, cn, v, dr, r);
    endtask

    // Error-free phase: ng greens, ny yellows, one red; sticky error state held.
    task automatic phase(input int d, input int ng, input int ny,
                         input int f, cd, cn, input int rot_end);
        for (int i = 0; i < ng; i++) lt(d, LT_GRN, 1'b0, 0, f, cd, cn, 1, d, -1);
        for (int i = 0; i < ny; i++) lt(d, LT_YEL, 1'b0, 0, f, cd, cn, 1, d, -1);
        lt(d, LT_RED, 1'b0, 0, f, cd, cn, 0, -1, rot_end);
    endtask

    task automatic chk_zero(input int i);
        cmp(tnum, i, "err_pulse",  int'(err_pulse),  0);
        cmp(tnum, i, "err_flag",   int'(err_flag),   0);
        cmp(tnum, i, "err_code",   int'(err_code),   0);
        cmp(tnum, i, "err_cnt",    int'(err_cnt),    0);
        cmp(tnum, i, "active_vld", int'(active_vld), 0);
        cmp(tnum, i, "active_dir", int'(active_dir), 0);
        cmp(tnum, i, "rot_cnt",    int'(rot_cnt),    0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; clr = 1'b0;
        nl = LT_RED; el = LT_RED; sl = LT_RED; wl = LT_RED;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_zero(900);
        sidx = 0;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        // T1 clean rotation
        tnum = 1; do_reset();
        phase(0, 3, 2, 0, 0, 0, 0);
        phase(1, 3, 2, 0, 0, 0, 0);
        phase(2, 3, 2, 0, 0, 0, 0);
        phase(3, 3, 2, 0, 0, 0, 1);

        // T2 conflict, then both drop straight to red
        tnum = 2; do_reset();
        step(LT_GRN, LT_GRN, LT_RED, LT_RED, 1'b0, 1, 1, 2, 1, 1, 0, 0);
        step(LT_RED, LT_RED, LT_RED, LT_RED, 1'b0, 1, 1, 2, 2, 0, -1, 0);

        // T3 G->R then illegal code; leaving 11 is silent
        tnum = 3; do_reset();
        for (int i = 0; i < 5; i++) lt(0, LT_GRN, 1'b0, 0, 0, 0, 0, 1, 0, 0);
        step(LT_RED, LT_RED, LT_RED, LT_RED, 1'b0, 1, 1, 3, 1, 0, -1, 0);
        step(LT_RED, LT_RED, LT_BAD, LT_RED, 1'b0, 1, 1, 3, 2, 0, -1, 0);
        step(LT_RED, LT_RED, LT_RED, LT_RED, 1'b0, 0, 1, 3, 2, 0, -1, 0);

        // T4 timing: short green, long green, long yellow (clr between)
        tnum = 4; do_reset();
        lt(0, LT_GRN, 1'b0, 0, 0, 0, 0, 1, 0, 0);
        lt(0, LT_GRN, 1'b0, 0, 0, 0, 0, 1, 0, 0);
        lt(0, LT_YEL, 1'b0, 1, 1, 5, 1, 1, 0, 0);
        lt(0, LT_YEL, 1'b0, 0, 1, 5, 1, 1, 0, 0);
        lt(0, LT_RED, 1'b1, 0, 0, 0, 0, 0, -1, 0);
        for (int i = 0; i < 16; i++) lt(1, LT_GRN, 1'b0, 0, 0, 0, 0, 1, 1, 0);
        lt(1, LT_GRN, 1'b0, 1, 1, 6, 1, 1, 1, 0);
        lt(1, LT_GRN, 1'b0, 0, 1, 6, 1, 1, 1, 0);
        lt(1, LT_YEL, 1'b0, 0, 1, 6, 1, 1, 1, 0);
        lt(1, LT_YEL, 1'b0, 0, 1, 6, 1, 1, 1, 0);
        lt(1, LT_RED, 1'b1, 0, 0, 0, 0, 0, -1, 0);
        for (int i = 0; i < 3; i++) lt(2, LT_GRN, 1'b0, 0, 0, 0, 0, 1, 2, 0);
        for (int i = 0; i < 3; i++) lt(2, LT_YEL, 1'b0, 0, 0, 0, 0, 1, 2, 0);
        lt(2, LT_RED, 1'b0, 1, 1, 7, 1, 0, -1, 0);

        // T5 order skip: N, E, W -> code 4, no rotation; clr vs violation
        tnum = 5; do_reset();
        phase(0, 3, 2, 0, 0, 0, 0);
        phase(1, 3, 2, 0, 0, 0, 0);
        lt(3, LT_GRN, 1'b0, 1, 1, 4, 1, 1, 3, 0);
        lt(3, LT_GRN, 1'b0, 0, 1, 4, 1, 1, 3, 0);
        lt(3, LT_GRN, 1'b0, 0, 1, 4, 1, 1, 3, 0);
        lt(3, LT_YEL, 1'b0, 0, 1, 4, 1, 1, 3, 0);
        lt(3, LT_YEL, 1'b0, 0, 1, 4, 1, 1, 3, 0);
        lt(3, LT_RED, 1'b0, 0, 1, 4, 1, 0, -1, 0);
        step(LT_RED, LT_RED, LT_RED, LT_RED, 1'b1, 0, 0, 0, 0, 0, -1, 0);
        step(LT_BAD, LT_RED, LT_RED, LT_RED, 1'b1, 1, 0, 0, 0, 0, -1, 0);
        step(LT_RED, LT_RED, LT_RED, LT_RED, 1'b0, 0, 0, 0, 0, 0, -1, 0);

        // T6 async reset mid-green, E green across release
        tnum = 6; do_reset();
        step(LT_GRN, LT_GRN, LT_RED, LT_RED, 1'b0, 1, 1, 2, 1, 1, 0, 0);
        step(LT_GRN, LT_RED, LT_RED, LT_RED, 1'b0, 1, 1, 2, 2, 1, 0, 0);
        step(LT_GRN, LT_RED, LT_RED, LT_RED, 1'b0, 0, 1, 2, 2, 1, 0, 0);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        chk_zero(901);
        @(negedge clk);
        nl = LT_RED; el = LT_GRN;
        @(negedge clk);
        rst = 1'b1;
        apply(LT_RED, LT_GRN, LT_RED, LT_RED, 1'b0, 0, 0, 0, 0, 1, 1, 0);
        step(LT_RED, LT_GRN, LT_RED, LT_RED, 1'b0, 0, 0, 0, 0, 1, 1, 0);

        // T7 err_cnt saturation at 255, then clr
        tnum = 7; do_reset();
        for (int i = 0; i < 260; i++)
            step(LT_BAD, LT_RED, LT_RED, LT_RED, 1'b0, 1, 1, 1, (i < 255) ? i + 1 : 255, 0, -1, 0);
        step(LT_RED, LT_RED, LT_RED, LT_RED, 1'b0, 0, 1, 1, 255, 0, -1, 0);
        step(LT_RED, LT_RED, LT_RED, LT_RED, 1'b1, 0, 0, 0, 0, 0, -1, 0);

        for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
        @(posedge clk); #2;
        if (q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
